// File: rtl/alu_issue_stage.sv
// Decode/issue pipeline register for RV32I ALU work.
// One-entry skid-free stage: decode combinationally, register on accept.
package ALU_pkg;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
endpackage

module alu_issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] INSTR,
  input  logic [31:0] PC,
  input  logic [31:0] RS1_DATA,
  input  logic [31:0] RS2_DATA,
  input  logic        FLUSH,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OP_A,
  output logic [31:0] OP_B,
  output logic [3:0]  ALUCTRL,
  output logic [4:0]  RD,
  output logic        RD_WE,
  output logic        IS_BRANCH,
  output logic [2:0]  BR_FUNCT3,
  output logic        ILLEGAL
);
  import ALU_pkg::*;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_s, imm_u, shamt;
  logic [31:0] d_a, d_b;
  logic [3:0]  d_op;
  logic        d_we, d_br, d_ill;
  logic        accept;

  assign opc   = INSTR[6:0];
  assign f3    = INSTR[14:12];
  assign f7    = INSTR[31:25];
  assign rd    = INSTR[11:7];
  assign imm_i = {{20{INSTR[31]}}, INSTR[31:20]};
  assign imm_s = {{20{INSTR[31]}}, INSTR[31:25], INSTR[11:7]};
  assign imm_u = {INSTR[31:12], 12'b0};
  assign shamt = {27'b0, INSTR[24:20]};

  assign IN_READY = !OUT_VALID || OUT_READY;
  assign accept   = IN_VALID && IN_READY;

  function automatic logic [3:0] f3_op(input logic [2:0] f);
    case (f)
      3'b000:  f3_op = ALU_ADD;
      3'b001:  f3_op = ALU_SLL;
      3'b010:  f3_op = ALU_SLT;
      3'b011:  f3_op = ALU_SLTU;
      3'b100:  f3_op = ALU_XOR;
      3'b101:  f3_op = ALU_SRL;
      3'b110:  f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase
  endfunction

  always_comb begin
    d_a   = '0;
    d_b   = '0;
    d_op  = ALU_ADD;
    d_we  = 1'b0;
    d_br  = 1'b0;
    d_ill = 1'b0;
    unique case (1'b1)
      opc == 7'b0110011: begin
        d_a  = RS1_DATA;
        d_b  = RS2_DATA;
        d_we = 1'b1;
        if (f7 == 7'b0)
          d_op = f3_op(f3);
        else if (f7 == 7'b0100000 && f3 == 3'b000)
          d_op = ALU_SUB;
        else if (f7 == 7'b0100000 && f3 == 3'b101)
          d_op = ALU_SRA;
        else
          d_ill = 1'b1;
      end
      opc == 7'b0010011: begin
        d_a  = RS1_DATA;
        d_b  = imm_i;
        d_we = 1'b1;
        d_op = f3_op(f3);
        // Shift-immediates reuse imm[11:5] as funct7
        if (f3 == 3'b001) begin
          d_b   = shamt;
          d_ill = (f7 != 7'b0);
        end else if (f3 == 3'b101) begin
          d_b = shamt;
          if (f7 == 7'b0100000)
            d_op = ALU_SRA;
          else if (f7 != 7'b0)
            d_ill = 1'b1;
        end
      end
      opc == 7'b0110111: begin
        d_b  = imm_u;
        d_we = 1'b1;
      end
      opc == 7'b0010111: begin
        d_a  = PC;
        d_b  = imm_u;
        d_we = 1'b1;
      end
      opc == 7'b0000011: begin
        d_a  = RS1_DATA;
        d_b  = imm_i;
        d_we = 1'b1;
      end
      opc == 7'b0100011: begin
        d_a = RS1_DATA;
        d_b = imm_s;
      end
      opc == 7'b1100011: begin
        d_a  = RS1_DATA;
        d_b  = RS2_DATA;
        d_br = 1'b1;
        case (f3[2:1])
          2'b00:   d_op = ALU_SUB;
          2'b10:   d_op = ALU_SLT;
          2'b11:   d_op = ALU_SLTU;
          default: d_ill = 1'b1;
        endcase
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_a  = '0;
      d_b  = '0;
      d_op = ALU_ADD;
      d_we = 1'b0;
      d_br = 1'b0;
    end
    if (rd == 5'd0)
      d_we = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OUT_VALID <= 1'b0;
      OP_A      <= '0;
      OP_B      <= '0;
      ALUCTRL   <= ALU_ADD;
      RD        <= '0;
      RD_WE     <= 1'b0;
      IS_BRANCH <= 1'b0;
      BR_FUNCT3 <= '0;
      ILLEGAL   <= 1'b0;
    end else begin
      // Flush wins over a same-cycle accept
      if (FLUSH)
        OUT_VALID <= 1'b0;
      else if (accept)
        OUT_VALID <= 1'b1;
      else if (OUT_READY)
        OUT_VALID <= 1'b0;
      if (accept && !FLUSH) begin
        OP_A      <= d_a;
        OP_B      <= d_b;
        ALUCTRL   <= d_op;
        RD        <= rd;
        RD_WE     <= d_we;
        IS_BRANCH <= d_br;
        BR_FUNCT3 <= f3;
        ILLEGAL   <= d_ill;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage.
// Hand-computed decode vectors plus handshake scenarios.
module tb_alu_issue_stage;
  import ALU_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] INSTR = '0;
  logic [31:0] PC = '0;
  logic [31:0] RS1_DATA = '0;
  logic [31:0] RS2_DATA = '0;
  logic        FLUSH = 1'b0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [31:0] OP_A, OP_B;
  logic [3:0]  ALUCTRL;
  logic [4:0]  RD;
  logic        RD_WE, IS_BRANCH, ILLEGAL;
  logic [2:0]  BR_FUNCT3;

  int vectors = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .INSTR(INSTR), .PC(PC),
    .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA),
    .FLUSH(FLUSH),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OP_A(OP_A), .OP_B(OP_B), .ALUCTRL(ALUCTRL),
    .RD(RD), .RD_WE(RD_WE), .IS_BRANCH(IS_BRANCH),
    .BR_FUNCT3(BR_FUNCT3), .ILLEGAL(ILLEGAL)
  );

  task automatic issue(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b);
    INSTR = i; PC = p; RS1_DATA = a; RS2_DATA = b;
    IN_VALID = 1'b1;
    @(posedge clk); #1;
    IN_VALID = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", OUT_VALID); end
    vectors++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", IN_READY); end
    vectors++; if ({OP_A, OP_B} !== 64'd0) begin errors++; $display("FAIL rst_ops got %h %h exp 0 0", OP_A, OP_B); end
    vectors++; if (ALUCTRL !== ALU_ADD) begin errors++; $display("FAIL rst_ctrl got %0d exp %0d", ALUCTRL, ALU_ADD); end
    vectors++; if ({RD, RD_WE, IS_BRANCH, BR_FUNCT3, ILLEGAL} !== 11'd0) begin errors++; $display("FAIL rst_misc got %b exp 0", {RD, RD_WE, IS_BRANCH, BR_FUNCT3, ILLEGAL}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_op;
    OUT_READY = 1'b1;
    issue(32'h002081B3, 32'h0, 32'd5, 32'd7);
    vectors++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", OUT_VALID); end
    vectors++; if (ALUCTRL !== ALU_ADD) begin errors++; $display("FAIL add_ctrl got %0d exp %0d", ALUCTRL, ALU_ADD); end
    vectors++; if ({OP_A, OP_B} !== {32'd5, 32'd7}) begin errors++; $display("FAIL add_ops got %h %h exp 5 7", OP_A, OP_B); end
    vectors++; if ({RD, RD_WE, ILLEGAL, IS_BRANCH} !== {5'd3, 3'b100}) begin errors++; $display("FAIL add_rd got rd=%0d we=%b ill=%b br=%b exp 3 1 0 0", RD, RD_WE, ILLEGAL, IS_BRANCH); end
    issue(32'h402081B3, 32'h0, 32'd9, 32'd4);
    vectors++; if ({ALUCTRL, ILLEGAL} !== {ALU_SUB, 1'b0}) begin errors++; $display("FAIL sub_ctrl got %0d ill=%b exp %0d 0", ALUCTRL, ILLEGAL, ALU_SUB); end
    issue(32'h4020C1B3, 32'h0, 32'd9, 32'd4);
    vectors++; if ({ILLEGAL, RD_WE, OP_A, OP_B, ALUCTRL} !== {2'b10, 64'd0, ALU_ADD}) begin errors++; $display("FAIL xor_f7_illegal got ill=%b we=%b a=%h b=%h ctrl=%0d exp 1 0 0 0 0", ILLEGAL, RD_WE, OP_A, OP_B, ALUCTRL); end
    issue(32'h00208033, 32'h0, 32'd1, 32'd2);
    vectors++; if ({RD, RD_WE} !== 6'd0) begin errors++; $display("FAIL rd0_we got rd=%0d we=%b exp 0 0", RD, RD_WE); end
  endtask

  task automatic test_imm;
    issue(32'h40335293, 32'h0, 32'h80000000, 32'hDEAD);
    vectors++; if ({ALUCTRL, OP_A, OP_B, RD, RD_WE} !== {ALU_SRA, 32'h80000000, 32'd3, 5'd5, 1'b1}) begin errors++; $display("FAIL srai got ctrl=%0d a=%h b=%h rd=%0d we=%b exp %0d 80000000 3 5 1", ALUCTRL, OP_A, OP_B, RD, RD_WE, ALU_SRA); end
    issue(32'hFFF00093, 32'h0, 32'd10, 32'd0);
    vectors++; if ({ALUCTRL, OP_A, OP_B} !== {ALU_ADD, 32'd10, 32'hFFFFFFFF}) begin errors++; $display("FAIL addi_neg got ctrl=%0d a=%h b=%h exp 0 a ffffffff", ALUCTRL, OP_A, OP_B); end
    issue(32'h40209093, 32'h0, 32'd10, 32'd0);
    vectors++; if ({ILLEGAL, RD_WE} !== 2'b10) begin errors++; $display("FAIL slli_f7 got ill=%b we=%b exp 1 0", ILLEGAL, RD_WE); end
    issue(32'h123450B7, 32'h0, 32'd77, 32'd88);
    vectors++; if ({ALUCTRL, OP_A, OP_B, RD} !== {ALU_ADD, 32'd0, 32'h12345000, 5'd1}) begin errors++; $display("FAIL lui got ctrl=%0d a=%h b=%h rd=%0d exp 0 0 12345000 1", ALUCTRL, OP_A, OP_B, RD); end
    issue(32'h00001117, 32'h100, 32'd77, 32'd88);
    vectors++; if ({ALUCTRL, OP_A, OP_B, RD_WE} !== {ALU_ADD, 32'h100, 32'h1000, 1'b1}) begin errors++; $display("FAIL auipc got ctrl=%0d a=%h b=%h we=%b exp 0 100 1000 1", ALUCTRL, OP_A, OP_B, RD_WE); end
  endtask

  task automatic test_mem_branch;
    issue(32'hFFC0A283, 32'h0, 32'h1000, 32'd0);
    vectors++; if ({OP_A, OP_B, RD_WE, RD} !== {32'h1000, 32'hFFFFFFFC, 1'b1, 5'd5}) begin errors++; $display("FAIL load got a=%h b=%h we=%b rd=%0d exp 1000 fffffffc 1 5", OP_A, OP_B, RD_WE, RD); end
    issue(32'hFE20AE23, 32'h0, 32'h2000, 32'd3);
    vectors++; if ({OP_A, OP_B, RD_WE, ALUCTRL} !== {32'h2000, 32'hFFFFFFFC, 1'b0, ALU_ADD}) begin errors++; $display("FAIL store got a=%h b=%h we=%b ctrl=%0d exp 2000 fffffffc 0 0", OP_A, OP_B, RD_WE, ALUCTRL); end
    issue(32'h0020C063, 32'h0, 32'd11, 32'd22);
    vectors++; if ({ALUCTRL, IS_BRANCH, BR_FUNCT3, RD_WE} !== {ALU_SLT, 1'b1, 3'd4, 1'b0}) begin errors++; $display("FAIL blt got ctrl=%0d br=%b f3=%0d we=%b exp %0d 1 4 0", ALUCTRL, IS_BRANCH, BR_FUNCT3, RD_WE, ALU_SLT); end
    vectors++; if ({OP_A, OP_B} !== {32'd11, 32'd22}) begin errors++; $display("FAIL blt_ops got %h %h exp b 16", OP_A, OP_B); end
    issue(32'h0020A063, 32'h0, 32'd11, 32'd22);
    vectors++; if ({ILLEGAL, IS_BRANCH} !== 2'b10) begin errors++; $display("FAIL br_f3_010 got ill=%b br=%b exp 1 0", ILLEGAL, IS_BRANCH); end
    issue(32'hFFFFFFFF, 32'h0, 32'd1, 32'd2);
    vectors++; if ({ILLEGAL, RD_WE, OP_A, OP_B, OUT_VALID} !== {2'b10, 64'd0, 1'b1}) begin errors++; $display("FAIL all_ones got ill=%b we=%b a=%h b=%h v=%b exp 1 0 0 0 1", ILLEGAL, RD_WE, OP_A, OP_B, OUT_VALID); end
  endtask

  task automatic test_back_to_back;
    OUT_READY = 1'b1;
    INSTR = 32'h002081B3; RS1_DATA = 32'd1; RS2_DATA = 32'd2; IN_VALID = 1'b1;
    @(posedge clk); #1;
    INSTR = 32'h402081B3; RS1_DATA = 32'd30; RS2_DATA = 32'd4;
    vectors++; if ({OUT_VALID, OP_A, ALUCTRL} !== {1'b1, 32'd1, ALU_ADD}) begin errors++; $display("FAIL b2b_first got v=%b a=%h ctrl=%0d exp 1 1 0", OUT_VALID, OP_A, ALUCTRL); end
    @(posedge clk); #1;
    IN_VALID = 1'b0;
    vectors++; if ({OUT_VALID, OP_A, ALUCTRL} !== {1'b1, 32'd30, ALU_SUB}) begin errors++; $display("FAIL b2b_second got v=%b a=%h ctrl=%0d exp 1 1e 1", OUT_VALID, OP_A, ALUCTRL); end
    @(posedge clk); #1;
    vectors++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL pop_empty got %b exp 0", OUT_VALID); end
  endtask

  task automatic test_backpressure;
    OUT_READY = 1'b1;
    issue(32'h002081B3, 32'h0, 32'd5, 32'd7);
    OUT_READY = 1'b0;
    INSTR = 32'h123450B7; IN_VALID = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      vectors++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL stall_ready c=%0d got %b exp 0", c, IN_READY); end
      vectors++; if ({OUT_VALID, OP_A, OP_B, RD} !== {1'b1, 32'd5, 32'd7, 5'd3}) begin errors++; $display("FAIL stall_hold c=%0d got v=%b a=%h b=%h rd=%0d exp 1 5 7 3", c, OUT_VALID, OP_A, OP_B, RD); end
    end
    OUT_READY = 1'b1;
    #1;
    vectors++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL drain_ready got %b exp 1", IN_READY); end
    @(posedge clk); #1;
    IN_VALID = 1'b0;
    vectors++; if ({OUT_VALID, OP_A, OP_B, RD} !== {1'b1, 32'd0, 32'h12345000, 5'd1}) begin errors++; $display("FAIL drain_push got v=%b a=%h b=%h rd=%0d exp 1 0 12345000 1", OUT_VALID, OP_A, OP_B, RD); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush;
    OUT_READY = 1'b1;
    INSTR = 32'h002081B3; IN_VALID = 1'b1; FLUSH = 1'b1;
    #1;
    vectors++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", IN_READY); end
    @(posedge clk); #1;
    IN_VALID = 1'b0; FLUSH = 1'b0;
    vectors++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL flush_accept got %b exp 0", OUT_VALID); end
    issue(32'h002081B3, 32'h0, 32'd5, 32'd7);
    OUT_READY = 1'b0; FLUSH = 1'b1;
    @(posedge clk); #1;
    FLUSH = 1'b0;
    vectors++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL flush_held got %b exp 0", OUT_VALID); end
    OUT_READY = 1'b1;
  endtask

  task automatic test_reset_stall;
    OUT_READY = 1'b1;
    issue(32'h0020C063, 32'h0, 32'd11, 32'd22);
    OUT_READY = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    vectors++; if ({OUT_VALID, IN_READY} !== 2'b01) begin errors++; $display("FAIL async_rst_hs got v=%b rdy=%b exp 0 1", OUT_VALID, IN_READY); end
    vectors++; if ({OP_A, OP_B, ALUCTRL, RD, RD_WE, IS_BRANCH, BR_FUNCT3, ILLEGAL} !== {64'd0, ALU_ADD, 11'd0}) begin errors++; $display("FAIL async_rst_pay got a=%h b=%h ctrl=%0d br=%b f3=%0d exp 0 0 0 0 0", OP_A, OP_B, ALUCTRL, IS_BRANCH, BR_FUNCT3); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    OUT_READY = 1'b1;
  endtask

  initial begin
    test_reset;
    test_op;
    test_imm;
    test_mem_branch;
    test_back_to_back;
    test_backpressure;
    test_flush;
    test_reset_stall;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
